piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//   Parallel-in serial-out stage feeding the 4-bit SIPO shift register.
//   Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit
//   per CLK cycle on sout, with busy/last framing.
//   Back-to-back words stream with no idle gap.
// PARAMETERS
//   WIDTH      4   bits per word; must be >= 2
//   MSB_FIRST  1   1: din[WIDTH-1] is sent first, so a left-shifting SIPO ends
//                  with Q == din; 0: din[0] is sent first
// PORTS
//   CLK        in   1      single clock, rising-edge
//   Reset_n    in   1      asynchronous, active-low reset
//   din        in   WIDTH  parallel word to send
//   din_valid  in   1      din is valid
//   din_ready  out  1      block can take a word this cycle
//   sout       out  1      serial data bit (feeds SIPO D)
//   busy       out  1      sout carries a valid bit this cycle
//   last       out  1      sout carries the final bit of the current word
// BEHAVIOUR
//   - Clock and reset: one clock CLK; reset Reset_n is asynchronous and
//     active-low.
//   - Reset values (while Reset_n low):
//     - state = IDLE, shreg = 0, cnt = 0.
//     - sout = 0, busy = 0, last = 0, din_ready = 1.
//     - Handshake is ignored during reset.
//   - FSM states: IDLE, SHIFT.
//     - IDLE -> SHIFT on an edge with din_valid & din_ready.
//     - SHIFT -> SHIFT when cnt == WIDTH-1 and a new word is accepted.
//     - SHIFT -> IDLE when cnt == WIDTH-1 and no word is accepted.
//   - Handshake:
//     - din_ready = (state == IDLE) | (state == SHIFT & cnt == WIDTH-1);
//       combinational from state and cnt.
//     - A transfer occurs on an edge where din_valid & din_ready.
//     - din is captured into shreg on that edge and cnt is set to 0.
//   - Latency: the first bit appears on sout in the cycle after acceptance.
//     Bit k (k = 0..WIDTH-1) is presented k+1 cycles after acceptance.
//   - sout:
//     - MSB_FIRST = 1: sout = shreg[WIDTH-1]; shreg shifts left each edge.
//     - MSB_FIRST = 0: sout = shreg[0]; shreg shifts right each edge.
//     - Vacated bit position is filled with 0.
//     - sout is forced to 0 in IDLE.
//   - Framing outputs:
//     - busy = (state == SHIFT).
//     - last = (state == SHIFT & cnt == WIDTH-1): exactly one cycle per word.
//   - cnt: $clog2(WIDTH) bits, unsigned. Increments each SHIFT cycle and
//     never exceeds WIDTH-1. It does not wrap: it reloads to 0 on accept.
//   - Back-to-back: if a word is accepted in the last cycle, its first bit
//     follows on the next cycle. busy stays 1 and there is no bubble.
//   - din or din_valid changing while busy with cnt < WIDTH-1: no effect.
//     The word is not accepted and the in-flight word is unchanged.
//   - Reset mid-word:
//     - All outputs take their reset values immediately (asynchronously).
//     - The partial word is discarded and is not resumed.
//     - The first edge after reset release may accept a new word.
//   - No X on any output after reset, for any input sequence.
// STRUCTURE
//   - Shared package piso_pkg:
//     - ST_IDLE / ST_SHIFT state encoding localparams.
//     - Default WIDTH (4), matching the SIPO width.
//   - Sub-module serial_bit_counter:
//     - Ports: load, en, cnt, at_last.
//     - Parameter: WIDTH.
//     - Async active-low reset.
//   - Top level holds the FSM, shreg, and handshake/output logic.
// TESTING
//   1. Reset, then din = 4'b1011 valid for 1 cycle (MSB_FIRST=1)
//      -> sout = 1,0,1,1 on 4 consecutive cycles.
//      -> busy = 1 for exactly those 4 cycles; last only on the 4th.
//      -> din_ready = 0 on cycles 1-3.
//   2. din_valid held with 1011 then 0110
//      -> 8 contiguous bits 1,0,1,1,0,1,1,0; busy never drops.
//      -> din_ready = 1 only in IDLE and on each 4th bit.
//   3. Send 1100; assert Reset_n = 0 after 2 bits
//      -> sout = busy = last = 0 immediately.
//      -> After release, 0101 is sent fully as 0,1,0,1.
//   4. MSB_FIRST = 0, din = 1011 -> sout = 1,1,0,1.
//   5. din changed to 0000 with din_valid = 1 mid-word while sending 1001
//      -> output is still 1,0,0,1.
//      -> 0000 is accepted only at last and then sent.
//   6. Loopback into the 4-bit SIPO (D = sout) with its register cleared
//      -> SIPO Q == 4'b1011 on the edge after last for din = 1011.
//      -> Also checked for all 16 din values, MSB_FIRST = 1.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out serializer.
// State encoding, default word width and counter sizing.
package piso_pkg;

   localparam int PISO_WIDTH = 4;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   function automatic int cnt_bits(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Bit position counter for the serializer.
// Reloads to zero on load and saturates at WIDTH-1.
module serial_bit_counter
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_WIDTH
) (
   input  logic                       CLK,
   input  logic                       Reset_n,
   input  logic                       load,
   input  logic                       en,
   output logic [cnt_bits(WIDTH)-1:0] cnt,
   output logic                       at_last
);

   localparam int CW = cnt_bits(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] r_cnt;
   logic          w_at_last;

   assign w_at_last = (r_cnt == LAST);
   assign cnt       = r_cnt;
   assign at_last   = w_at_last;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= '0;
      end else if (en && !w_at_last) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready input and
// busy/last framing; back-to-back words stream without a gap.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = PISO_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             busy,
   output logic             last
);

   localparam int CW = cnt_bits(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [CW-1:0]    w_cnt;
   logic             w_at_last;
   logic             w_shift;
   logic             w_accept;
   logic             w_head;

   assign w_shift  = (r_state == ST_SHIFT);
   assign w_accept = din_valid & din_ready;
   assign w_head   = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

   assign din_ready = !w_shift | w_at_last;
   assign busy      = w_shift;
   assign last      = w_shift & (w_cnt == LAST);
   assign sout      = w_shift & w_head;

   serial_bit_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .load    (w_accept),
      .en      (w_shift),
      .cnt     (w_cnt),
      .at_last (w_at_last)
   );

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= ST_IDLE;
      end else if (w_accept) begin
         r_state <= ST_SHIFT;
      end else if (w_shift && w_at_last) begin
         r_state <= ST_IDLE;
      end
   end

   // Shift toward the output end; the vacated slot fills with zero.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_shreg <= '0;
      end else if (w_accept) begin
         r_shreg <= din;
      end else if (w_shift) begin
         if (MSB_FIRST) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
         end else begin
            r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
         end
      end
   end

endmodule
